// File: rtl/crush_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crush_bus_pkg
//  Description : Shared definitions for the crush bus Wishbone decoder.
//                Holds the bus widths, the default memory map, the decoder
//                FSM state type and the region-mask helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package crush_bus_pkg;

    // Wishbone bus widths
    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    // Width of the watchdog counter (covers TIMEOUT_CYCLES up to 65535)
    localparam int TO_CNT_W = 16;

    // Default memory map
    localparam logic [WB_ADR_W-1:0] DEF_S0_BASE = 32'h1000_0000;
    localparam logic [WB_ADR_W-1:0] DEF_S0_SIZE = 32'h0000_4000;
    localparam logic [WB_ADR_W-1:0] DEF_S1_BASE = 32'h2000_0000;
    localparam logic [WB_ADR_W-1:0] DEF_S1_SIZE = 32'h0000_1000;

    // Decoder FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Mask that clears the offset bits of a power-of-two region
    function automatic logic [WB_ADR_W-1:0] region_mask(input logic [WB_ADR_W-1:0] size);
        return ~(size - 32'd1);
    endfunction

endpackage : crush_bus_pkg
`default_nettype wire

// File: rtl/wb_addr_match.sv
`default_nettype none
// ============================================================================
//  Module      : wb_addr_match
//  Description : Unsigned region comparator. hit is high when adr lies in
//                [BASE, BASE+SIZE). SIZE must be a power of two and BASE
//                aligned to SIZE.
//  Ports       : adr (in, 32)  - address to test
//                hit (out, 1)  - address falls in the region
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_addr_match
    import crush_bus_pkg::*;
#(
    parameter logic [WB_ADR_W-1:0] BASE = DEF_S0_BASE,
    parameter logic [WB_ADR_W-1:0] SIZE = DEF_S0_SIZE
) (
    input  logic [WB_ADR_W-1:0] adr,
    output logic                hit
);

    localparam logic [WB_ADR_W-1:0] MASK = region_mask(SIZE);

    assign hit = ((adr & MASK) == BASE);

endmodule : wb_addr_match
`default_nettype wire

// File: rtl/wb_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : wb_decoder
//  Description : Single-master, two-slave Wishbone B4 classic address
//                decoder with optional bus watchdog. Slave 0 is memory,
//                slave 1 a peripheral region. The decode is registered in
//                IDLE; while BUSY the selected slave's terminations and read
//                data are passed combinationally to the master. Unmapped
//                addresses (and, with the watchdog, silent slaves) get a
//                one-cycle err from the ERR state.
//  Config      : `define CRUSH_BUS_TIMEOUT_EN to enable the watchdog; without
//                it BUSY waits indefinitely and TIMEOUT_CYCLES is ignored.
//  Ports       : clk_i, rst_i            - clock, sync active-high reset
//                m_*                     - master side (cyc/stb/we/adr/sel/
//                                          dat in; dat/ack/err/rty out)
//                s0_*, s1_*              - slave side (cyc/stb/we/adr/sel/
//                                          dat out; dat/ack/err/rty in)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_decoder
    import crush_bus_pkg::*;
#(
    parameter logic [WB_ADR_W-1:0] S0_BASE        = DEF_S0_BASE,
    parameter logic [WB_ADR_W-1:0] S0_SIZE        = DEF_S0_SIZE,
    parameter logic [WB_ADR_W-1:0] S1_BASE        = DEF_S1_BASE,
    parameter logic [WB_ADR_W-1:0] S1_SIZE        = DEF_S1_SIZE,
    parameter int                  TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,

    // Master port
    input  logic                m_cyc_i,
    input  logic                m_stb_i,
    input  logic                m_we_i,
    input  logic [WB_ADR_W-1:0] m_adr_i,
    input  logic [WB_SEL_W-1:0] m_sel_i,
    input  logic [WB_DAT_W-1:0] m_dat_i,
    output logic [WB_DAT_W-1:0] m_dat_o,
    output logic                m_ack_o,
    output logic                m_err_o,
    output logic                m_rty_o,

    // Slave 0 (memory)
    output logic                s0_cyc_o,
    output logic                s0_stb_o,
    output logic                s0_we_o,
    output logic [WB_ADR_W-1:0] s0_adr_o,
    output logic [WB_SEL_W-1:0] s0_sel_o,
    output logic [WB_DAT_W-1:0] s0_dat_o,
    input  logic [WB_DAT_W-1:0] s0_dat_i,
    input  logic                s0_ack_i,
    input  logic                s0_err_i,
    input  logic                s0_rty_i,

    // Slave 1 (peripherals)
    output logic                s1_cyc_o,
    output logic                s1_stb_o,
    output logic                s1_we_o,
    output logic [WB_ADR_W-1:0] s1_adr_o,
    output logic [WB_SEL_W-1:0] s1_sel_o,
    output logic [WB_DAT_W-1:0] s1_dat_o,
    input  logic [WB_DAT_W-1:0] s1_dat_i,
    input  logic                s1_ack_i,
    input  logic                s1_err_i,
    input  logic                s1_rty_i
);

    // Elaboration-time range check on the watchdog limit
    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("wb_decoder: TIMEOUT_CYCLES must be in 1..65535");
        end
    endgenerate

    state_t state;
    logic   sel_q;      // 0 = slave 0, 1 = slave 1

`ifdef CRUSH_BUS_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [TO_CNT_W-1:0] to_cnt;
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic s0_hit;
    logic s1_hit;

    wb_addr_match #(
        .BASE (S0_BASE),
        .SIZE (S0_SIZE)
    ) u_s0_match (
        .adr  (m_adr_i),
        .hit  (s0_hit)
    );

    wb_addr_match #(
        .BASE (S1_BASE),
        .SIZE (S1_SIZE)
    ) u_s1_match (
        .adr  (m_adr_i),
        .hit  (s1_hit)
    );

    // ------------------------------------------------------------------
    // Selected-slave return path
    // ------------------------------------------------------------------
    logic                busy;
    logic                sel_ack;
    logic                sel_err;
    logic                sel_rty;
    logic [WB_DAT_W-1:0] sel_dat;
    logic                sel_term;

    assign busy = (state == BUSY);

    always_comb begin
        sel_ack = s0_ack_i;
        sel_err = s0_err_i;
        sel_rty = s0_rty_i;
        sel_dat = s0_dat_i;
        if (sel_q) begin
            sel_ack = s1_ack_i;
            sel_err = s1_err_i;
            sel_rty = s1_rty_i;
            sel_dat = s1_dat_i;
        end
    end

    assign sel_term = sel_ack | sel_err | sel_rty;

    // Terminations are masked while reset is asserted so that a slave
    // acking in the reset cycle is never seen by the master.
    assign m_ack_o = ~rst_i & busy & sel_ack;
    assign m_rty_o = ~rst_i & busy & sel_rty;
    assign m_err_o = ~rst_i & ((busy & sel_err) | (state == ERR));
    assign m_dat_o = busy ? sel_dat : '0;

    // ------------------------------------------------------------------
    // Slave request path: strobes follow the master combinationally so a
    // master abort (cyc low) reaches the slave in the same cycle.
    // ------------------------------------------------------------------
    assign s0_cyc_o = busy & ~sel_q & m_cyc_i;
    assign s0_stb_o = busy & ~sel_q & m_stb_i;
    assign s1_cyc_o = busy &  sel_q & m_cyc_i;
    assign s1_stb_o = busy &  sel_q & m_stb_i;

    assign s0_we_o  = m_we_i;
    assign s0_adr_o = m_adr_i;
    assign s0_sel_o = m_sel_i;
    assign s0_dat_o = m_dat_i;
    assign s1_we_o  = m_we_i;
    assign s1_adr_o = m_adr_i;
    assign s1_sel_o = m_sel_i;
    assign s1_dat_o = m_dat_i;

    // ------------------------------------------------------------------
    // Decoder FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            sel_q <= 1'b0;
`ifdef CRUSH_BUS_TIMEOUT_EN
            to_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        // S0 is tested first so it wins on overlapping maps
                        if (s0_hit) begin
                            sel_q <= 1'b0;
                            state <= BUSY;
                        end else if (s1_hit) begin
                            sel_q <= 1'b1;
                            state <= BUSY;
                        end else begin
                            state <= ERR;
                        end
`ifdef CRUSH_BUS_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end
                end

                BUSY: begin
                    if (!m_cyc_i) begin
                        state <= IDLE;
                    end else if (sel_term) begin
                        state <= IDLE;
`ifdef CRUSH_BUS_TIMEOUT_EN
                    end else if (to_cnt == TO_LAST) begin
                        state <= ERR;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end

                ERR: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : wb_decoder
`default_nettype wire

// File: tb/tb_wb_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_decoder
//  Description : Self-checking bench for wb_decoder. Two behavioural slaves
//                with programmable response type and latency; expected
//                master terminations are queued as each access is issued
//                and compared when the decoder terminates the cycle.
//                Build with CRUSH_BUS_TIMEOUT_EN to exercise the watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_decoder;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_RTY  = 2;
    localparam int M_NONE = 3;

    localparam logic [31:0] S0_DATA = 32'hDEAD_BEEF;
    localparam logic [31:0] S1_DATA = 32'hCAFE_0001;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        m_cyc_i = 1'b0, m_stb_i = 1'b0, m_we_i = 1'b0;
    logic [31:0] m_adr_i = '0, m_dat_i = '0;
    logic [3:0]  m_sel_i = '0;
    logic [31:0] m_dat_o;
    logic        m_ack_o, m_err_o, m_rty_o;

    logic        s0_cyc_o, s0_stb_o, s0_we_o;
    logic [31:0] s0_adr_o, s0_dat_o;
    logic [3:0]  s0_sel_o;
    logic [31:0] s0_dat_i;
    logic        s0_ack_i, s0_err_i, s0_rty_i;

    logic        s1_cyc_o, s1_stb_o, s1_we_o;
    logic [31:0] s1_adr_o, s1_dat_o;
    logic [3:0]  s1_sel_o;
    logic [31:0] s1_dat_i;
    logic        s1_ack_i, s1_err_i, s1_rty_i;

    always #5 clk_i = ~clk_i;

    wb_decoder #(
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .clk_i    (clk_i),    .rst_i    (rst_i),
        .m_cyc_i  (m_cyc_i),  .m_stb_i  (m_stb_i),  .m_we_i   (m_we_i),
        .m_adr_i  (m_adr_i),  .m_sel_i  (m_sel_i),  .m_dat_i  (m_dat_i),
        .m_dat_o  (m_dat_o),  .m_ack_o  (m_ack_o),  .m_err_o  (m_err_o),
        .m_rty_o  (m_rty_o),
        .s0_cyc_o (s0_cyc_o), .s0_stb_o (s0_stb_o), .s0_we_o  (s0_we_o),
        .s0_adr_o (s0_adr_o), .s0_sel_o (s0_sel_o), .s0_dat_o (s0_dat_o),
        .s0_dat_i (s0_dat_i), .s0_ack_i (s0_ack_i), .s0_err_i (s0_err_i),
        .s0_rty_i (s0_rty_i),
        .s1_cyc_o (s1_cyc_o), .s1_stb_o (s1_stb_o), .s1_we_o  (s1_we_o),
        .s1_adr_o (s1_adr_o), .s1_sel_o (s1_sel_o), .s1_dat_o (s1_dat_o),
        .s1_dat_i (s1_dat_i), .s1_ack_i (s1_ack_i), .s1_err_i (s1_err_i),
        .s1_rty_i (s1_rty_i)
    );

    // ------------------------------------------------------------------
    // Behavioural slaves: respond once stb has been high for 'lat' cycles
    // ------------------------------------------------------------------
    int   s0_mode = M_ACK, s0_lat = 0, s0_cnt = 0;
    int   s1_mode = M_ACK, s1_lat = 0, s1_cnt = 0;
    logic s0_force = 1'b0;

    logic s0_rdy, s1_rdy;
    assign s0_rdy   = s0_stb_o && (s0_cnt >= s0_lat);
    assign s1_rdy   = s1_stb_o && (s1_cnt >= s1_lat);
    assign s0_dat_i = S0_DATA;
    assign s1_dat_i = S1_DATA;
    assign s0_ack_i = s0_force | (s0_rdy && s0_mode == M_ACK);
    assign s0_err_i = s0_rdy && s0_mode == M_ERR;
    assign s0_rty_i = s0_rdy && s0_mode == M_RTY;
    assign s1_ack_i = s1_rdy && s1_mode == M_ACK;
    assign s1_err_i = s1_rdy && s1_mode == M_ERR;
    assign s1_rty_i = s1_rdy && s1_mode == M_RTY;

    always @(posedge clk_i) begin
        s0_cnt <= (s0_stb_o && !(s0_ack_i || s0_err_i || s0_rty_i)) ? s0_cnt + 1 : 0;
        s1_cnt <= (s1_stb_o && !(s1_ack_i || s1_err_i || s1_rty_i)) ? s1_cnt + 1 : 0;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic [31:0] dat;
    } term_t;

    term_t exp_q[$];
    logic  s1_seen = 1'b0;

    task automatic push_exp(input logic ack, input logic err, input logic rty, input logic [31:0] dat);
        term_t t;
        t.ack = ack; t.err = err; t.rty = rty; t.dat = dat;
        exp_q.push_back(t);
    endtask

    // Scoreboard monitor: every termination seen by the master is matched
    // against the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (s1_stb_o) s1_seen = 1'b1;
        if (m_ack_o || m_err_o || m_rty_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_term", {29'd0, m_ack_o, m_err_o, m_rty_o}, 32'd0);
            end else begin
                term_t t;
                t = exp_q.pop_front();
                chk("term_flags", {29'd0, m_ack_o, m_err_o, m_rty_o}, {29'd0, t.ack, t.err, t.rty});
                chk("term_data", m_dat_o, t.dat);
            end
        end
    end

    // ------------------------------------------------------------------
    // Master tasks
    // ------------------------------------------------------------------
    task automatic start_xfer(input logic [31:0] adr, input logic we,
                              input logic [3:0] sel, input logic [31:0] dat);
        @(posedge clk_i); #1;
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
        m_adr_i = adr;  m_sel_i = sel;  m_dat_i = dat;
        // Decode cycle: nothing may reach a slave or the master yet
        @(negedge clk_i);
        chk("decode_no_term", {29'd0, m_ack_o, m_err_o, m_rty_o}, 32'd0);
        chk("decode_no_stb", {30'd0, s0_stb_o, s1_stb_o}, 32'd0);
    endtask

    // Wait for a termination; reports cycles to it and cycles a slave cyc was high
    task automatic wait_term(input int budget, output int cycles, output int busy_cycles);
        cycles = 0;
        busy_cycles = 0;
        while (cycles < budget) begin
            @(negedge clk_i);
            cycles++;
            if (s0_cyc_o || s1_cyc_o) busy_cycles++;
            if (m_ack_o || m_err_o || m_rty_o) break;
        end
        if (!(m_ack_o || m_err_o || m_rty_o)) chk("term_timeout", 32'd0, 32'd1);
    endtask

    task automatic end_xfer();
        @(posedge clk_i); #1;
        m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [31:0] unmapped [4];
    int cyc, bcyc;

    initial begin
        unmapped[0] = 32'h3000_0000;
        unmapped[1] = 32'h1000_4000;   // one past S0
        unmapped[2] = 32'h2000_1000;   // one past S1
        unmapped[3] = 32'h0FFF_FFFC;   // just below S0

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_term", {29'd0, m_ack_o, m_err_o, m_rty_o}, 32'd0);
        chk("rst_dat", m_dat_o, 32'd0);
        chk("rst_strobes", {28'd0, s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o}, 32'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // Read from slave 0, ack one cycle after stb
        s0_mode = M_ACK; s0_lat = 1; s1_seen = 1'b0;
        push_exp(1'b1, 1'b0, 1'b0, S0_DATA);
        start_xfer(32'h1000_0010, 1'b0, 4'hF, 32'd0);
        wait_term(20, cyc, bcyc);
        chk("rd_cycles", cyc, 32'd2);
        end_xfer();
        chk("rd_no_s1_stb", {31'd0, s1_seen}, 32'd0);

        // Write to slave 1, forwarding of we/sel/dat/adr
        s1_mode = M_ACK; s1_lat = 0;
        push_exp(1'b1, 1'b0, 1'b0, S1_DATA);
        start_xfer(32'h2000_0004, 1'b1, 4'b0011, 32'h1234_5678);
        wait_term(20, cyc, bcyc);
        chk("wr_cycles", cyc, 32'd1);
        chk("wr_we", {31'd0, s1_we_o}, 32'd1);
        chk("wr_sel", {28'd0, s1_sel_o}, 32'h3);
        chk("wr_dat", s1_dat_o, 32'h1234_5678);
        chk("wr_adr", s1_adr_o, 32'h2000_0004);
        chk("wr_cyc_route", {30'd0, s0_cyc_o, s1_cyc_o}, 32'd1);
        end_xfer();

        // Unmapped addresses: one-cycle err, no slave strobes
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 1'b1, 1'b0, 32'd0);
            start_xfer(unmapped[i], 1'b0, 4'hF, 32'd0);
            wait_term(20, cyc, bcyc);
            chk("unmap_cycles", cyc, 32'd1);
            chk("unmap_busy", bcyc, 32'd0);
            end_xfer();
            @(negedge clk_i);
            chk("unmap_err_one_cycle", {31'd0, m_err_o}, 32'd0);
        end

        // Slave error at the top of S0, retry at the top of S1
        s0_mode = M_ERR; s0_lat = 2;
        push_exp(1'b0, 1'b1, 1'b0, S0_DATA);
        start_xfer(32'h1000_3FFC, 1'b0, 4'hF, 32'd0);
        wait_term(20, cyc, bcyc);
        chk("s0err_cycles", cyc, 32'd3);
        end_xfer();

        s1_mode = M_RTY; s1_lat = 1;
        push_exp(1'b0, 1'b0, 1'b1, S1_DATA);
        start_xfer(32'h2000_0FFF, 1'b0, 4'h1, 32'd0);
        wait_term(20, cyc, bcyc);
        chk("s1rty_cycles", cyc, 32'd2);
        end_xfer();

`ifdef CRUSH_BUS_TIMEOUT_EN
        // Watchdog: silent slave -> 8 BUSY cycles then one-cycle err
        s0_mode = M_NONE;
        push_exp(1'b0, 1'b1, 1'b0, 32'd0);
        start_xfer(32'h1000_0000, 1'b0, 4'hF, 32'd0);
        wait_term(40, cyc, bcyc);
        chk("to_busy_cycles", bcyc, 32'd8);
        chk("to_err_cycle", cyc, 32'd9);
        end_xfer();
        @(negedge clk_i);
        chk("to_err_one_cycle", {31'd0, m_err_o}, 32'd0);
        s0_mode = M_ACK; s0_lat = 0;
        push_exp(1'b1, 1'b0, 1'b0, S0_DATA);
        start_xfer(32'h1000_0000, 1'b0, 4'hF, 32'd0);
        wait_term(20, cyc, bcyc);
        chk("to_recover_cycles", cyc, 32'd1);
        end_xfer();
`else
        // No watchdog: silent slave keeps the bus BUSY
        s0_mode = M_NONE;
        start_xfer(32'h1000_0000, 1'b0, 4'hF, 32'd0);
        repeat (20) @(negedge clk_i);
        chk("nowd_still_busy", {31'd0, s0_cyc_o}, 32'd1);
        end_xfer();
        @(negedge clk_i);
        chk("nowd_abort_idle", {31'd0, s0_cyc_o}, 32'd0);
`endif

        // Master abort three cycles into BUSY
        s0_mode = M_NONE;
        start_xfer(32'h1000_0008, 1'b0, 4'hF, 32'd0);
        repeat (3) @(negedge clk_i);
        chk("abort_cyc_before", {31'd0, s0_cyc_o}, 32'd1);
        #1 m_cyc_i = 1'b0;
        #1 chk("abort_cyc_comb", {31'd0, s0_cyc_o}, 32'd0);
        chk("abort_no_term", {29'd0, m_ack_o, m_err_o, m_rty_o}, 32'd0);
        @(posedge clk_i); #1 m_stb_i = 1'b0;
        @(negedge clk_i);
        chk("abort_idle", {30'd0, s0_stb_o, s0_cyc_o}, 32'd0);
        s0_mode = M_ACK; s0_lat = 0;
        push_exp(1'b1, 1'b0, 1'b0, S0_DATA);
        start_xfer(32'h1000_0008, 1'b0, 4'hF, 32'd0);
        wait_term(20, cyc, bcyc);
        chk("abort_recover_cycles", cyc, 32'd1);
        end_xfer();

        // Reset mid-BUSY while the slave acks in the same cycle
        s0_mode = M_NONE;
        start_xfer(32'h1000_0020, 1'b0, 4'hF, 32'd0);
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b1; s0_force = 1'b1;
        @(negedge clk_i);
        chk("rst_ack_gated", {31'd0, m_ack_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; s0_force = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(negedge clk_i);
        chk("rst_busy_term", {29'd0, m_ack_o, m_err_o, m_rty_o}, 32'd0);
        chk("rst_busy_dat", m_dat_o, 32'd0);
        chk("rst_busy_strobes", {28'd0, s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o}, 32'd0);

        repeat (2) @(negedge clk_i);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, limit 200000");
        $fatal(1, "global timeout");
    end

endmodule : tb_wb_decoder
`default_nettype wire
